// File: rtl/pipelined_reduce_tree_pkg.sv
// reduce_tree_pkg: op encodings, per-level operator selection and counter width
package reduce_tree_pkg;
  localparam logic [1:0] OP_ALT = 2'd0;
  localparam logic [1:0] OP_AND = 2'd1;
  localparam logic [1:0] OP_OR  = 2'd2;
  localparam logic [1:0] OP_XOR = 2'd3;
  localparam int CNT_W = 16;
  function automatic logic [1:0] level_op(input logic [1:0] op, input int k);
    return op == OP_ALT ? ((k % 2 == 1) ? OP_AND : OP_OR) : op;
  endfunction
  function automatic logic apply_op(input logic [1:0] f, input logic a, input logic b);
    return f == OP_AND ? a & b : f == OP_OR ? a | b : a ^ b;
  endfunction
endpackage

// File: rtl/pipelined_reduce_tree_if.sv
// pipelined_reduce_tree_if: input/output valid-ready streams of the reduce tree
interface pipelined_reduce_tree_if #(parameter int GATES_NO = 16);
  logic                in_valid;
  logic                in_ready;
  logic [GATES_NO-1:0] x;
  logic [GATES_NO-1:0] y;
  logic [1:0]          op;
  logic                out_valid;
  logic                out_ready;
  logic                out_z;
  logic [1:0]          out_op;
  modport master (output in_valid, x, y, op, out_ready, input in_ready, out_valid, out_z, out_op);
  modport slave  (input in_valid, x, y, op, out_ready, output in_ready, out_valid, out_z, out_op);
endinterface

// File: rtl/pipelined_reduce_tree_stage.sv
// reduce_stage: pairwise reduce of IN_W bits to IN_W/2, registered with op and valid
module reduce_stage
  import reduce_tree_pkg::*;
#(
  parameter int IN_W      = 2,
  parameter int LEVEL_IDX = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adv,
  input  logic              in_valid,
  input  logic [1:0]        in_op,
  input  logic [IN_W-1:0]   in_d,
  output logic              valid,
  output logic [1:0]        op,
  output logic [IN_W/2-1:0] d
);
  logic [1:0]        f;
  logic [IN_W/2-1:0] r;
  assign f = level_op(in_op, LEVEL_IDX);
  for (genvar i = 0; i < IN_W / 2; i++) begin : g_red
    assign r[i] = apply_op(f, in_d[2*i], in_d[2*i+1]);
  end
  // shift data, op and valid together whenever the pipeline advances
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      op    <= 2'd0;
      d     <= '0;
    end else if (adv) begin
      valid <= in_valid;
      op    <= in_op;
      d     <= r;
    end
  end
endmodule

// File: rtl/pipelined_reduce_tree.sv
// pipelined_reduce_tree: LEVELS-stage registered OR/AND/XOR/ALT reduction of x and y to one bit
// Optional completed-transfer counter enabled by REDUCE_TREE_SAMPLE_CNT_EN.
module pipelined_reduce_tree
  import reduce_tree_pkg::*;
#(
  parameter int LEVELS = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  pipelined_reduce_tree_if.slave  bus
`ifdef REDUCE_TREE_SAMPLE_CNT_EN
  ,
  input  logic                    clr_cnt,
  output logic [CNT_W-1:0]        sample_cnt
`endif
);
  localparam int GATES_NO = 2 ** (LEVELS - 1);
  logic                  adv;
  logic [2*GATES_NO-1:0] leaves;
  assign adv          = !bus.out_valid | bus.out_ready;
  assign bus.in_ready = adv;
  for (genvar i = 0; i < GATES_NO; i++) begin : g_leaf
    assign leaves[2*i]   = bus.x[i];
    assign leaves[2*i+1] = bus.y[i];
  end
  for (genvar g = 0; g < LEVELS; g++) begin : lv
    localparam int IW = 2 ** (LEVELS - g);
    logic            v;
    logic [1:0]      o;
    logic [IW/2-1:0] d;
    if (g == 0) begin : s
      reduce_stage #(.IN_W(IW), .LEVEL_IDX(1)) u_stage (
        .clk(clk), .rst(rst), .adv(adv),
        .in_valid(bus.in_valid), .in_op(bus.op), .in_d(leaves),
        .valid(v), .op(o), .d(d)
      );
    end else begin : s
      reduce_stage #(.IN_W(IW), .LEVEL_IDX(g + 1)) u_stage (
        .clk(clk), .rst(rst), .adv(adv),
        .in_valid(lv[g-1].v), .in_op(lv[g-1].o), .in_d(lv[g-1].d),
        .valid(v), .op(o), .d(d)
      );
    end
  end
  assign bus.out_valid = lv[LEVELS-1].v;
  assign bus.out_z     = lv[LEVELS-1].d[0];
  assign bus.out_op    = lv[LEVELS-1].o;
`ifdef REDUCE_TREE_SAMPLE_CNT_EN
  // count completed output transfers, saturating; clear beats increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sample_cnt <= '0;
    else if (clr_cnt) sample_cnt <= '0;
    else if (bus.out_valid && bus.out_ready && sample_cnt != '1) sample_cnt <= sample_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_pipelined_reduce_tree.sv
// tb_pipelined_reduce_tree: directed self-checking bench for pipelined_reduce_tree (LEVELS=5)
module tb_pipelined_reduce_tree;
  import reduce_tree_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  pipelined_reduce_tree_if #(.GATES_NO(16)) bus ();
`ifdef REDUCE_TREE_SAMPLE_CNT_EN
  logic             clr_cnt = 1'b0;
  logic [CNT_W-1:0] sample_cnt;
`endif
  pipelined_reduce_tree #(.LEVELS(5)) dut (
    .clk(clk), .rst(rst), .bus(bus)
`ifdef REDUCE_TREE_SAMPLE_CNT_EN
    , .clr_cnt(clr_cnt), .sample_cnt(sample_cnt)
`endif
  );
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] o, input logic ez);
    int n;
    bus.x = a; bus.y = b; bus.op = o; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, "_latency"}, n, 5);
    check({tag, "_z"}, bus.out_z, ez);
    check({tag, "_op"}, bus.out_op, o);
    step();
  endtask

  logic [15:0] vx[8];
  logic [15:0] vy[8];
  logic [1:0]  vo[8];
  logic        vz[8];
  int          oc[8];

  initial begin
    int  si, ri;
    logic seen, stalled, hz;
    logic [1:0] hop;
    bus.in_valid = 1'b0; bus.x = '0; bus.y = '0; bus.op = '0; bus.out_ready = 1'b1;
    vx[0] = 16'h0001; vy[0] = 16'h0000; vo[0] = OP_XOR; vz[0] = 1'b1;
    vx[1] = 16'h0003; vy[1] = 16'h0000; vo[1] = OP_XOR; vz[1] = 1'b0;
    vx[2] = 16'hFFFF; vy[2] = 16'hFFFF; vo[2] = OP_AND; vz[2] = 1'b1;
    vx[3] = 16'h0000; vy[3] = 16'h0000; vo[3] = OP_OR;  vz[3] = 1'b0;
    vx[4] = 16'hFFFF; vy[4] = 16'hFFFF; vo[4] = OP_ALT; vz[4] = 1'b1;
    vx[5] = 16'h0003; vy[5] = 16'h0003; vo[5] = OP_ALT; vz[5] = 1'b0;
    vx[6] = 16'h0000; vy[6] = 16'h0400; vo[6] = OP_OR;  vz[6] = 1'b1;
    vx[7] = 16'hFFFF; vy[7] = 16'h7FFF; vo[7] = OP_AND; vz[7] = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_z", bus.out_z, 0);
    check("rst_out_op", bus.out_op, 0);
    check("rst_in_ready", bus.in_ready, 1);
    step();
    rst = 1'b0;
    step();
    // reset in the middle of a stream
    bus.x = 16'hFFFF; bus.y = 16'hFFFF; bus.op = OP_AND; bus.in_valid = 1'b1;
    repeat (3) step();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_z", bus.out_z, 0);
    step();
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      step();
      seen = seen | bus.out_valid;
    end
    check("midrst_no_stale", seen, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    // single samples with latency
    run_one("and_ones", 16'hFFFF, 16'hFFFF, OP_AND, 1'b1);
    run_one("and_fffe", 16'hFFFE, 16'hFFFF, OP_AND, 1'b0);
    run_one("xor_1", 16'h0001, 16'h0000, OP_XOR, 1'b1);
    run_one("xor_3", 16'h0003, 16'h0000, OP_XOR, 1'b0);
    run_one("alt_3", 16'h0003, 16'h0003, OP_ALT, 1'b0);
    run_one("alt_ones", 16'hFFFF, 16'hFFFF, OP_ALT, 1'b1);
    run_one("or_zero", 16'h0000, 16'h0000, OP_OR, 1'b0);
    run_one("or_msb", 16'h0000, 16'h8000, OP_OR, 1'b1);
    // streaming with a 3-cycle output stall
    si = 0; ri = 0; stalled = 1'b0; hz = 1'b0; hop = 2'd0;
    for (int c = 0; c < 40; c++) begin
      bus.out_ready = !(c >= 8 && c < 11);
      bus.in_valid = si < 8;
      if (si < 8) begin
        bus.x = vx[si]; bus.y = vy[si]; bus.op = vo[si];
      end
      #1;
      if (!bus.out_ready) check("stall_in_ready", bus.in_ready, 0);
      if (stalled) begin
        check("stall_z_hold", bus.out_z, hz);
        check("stall_op_hold", bus.out_op, hop);
      end
      if (bus.out_valid && bus.out_ready && ri < 8) begin
        check($sformatf("strm_z%0d", ri), bus.out_z, vz[ri]);
        check($sformatf("strm_op%0d", ri), bus.out_op, vo[ri]);
        oc[ri] = c;
        ri++;
      end
      stalled = bus.out_valid && !bus.out_ready;
      hz = bus.out_z;
      hop = bus.out_op;
      if (bus.in_valid && bus.in_ready) si++;
      step();
    end
    check("strm_count", ri, 8);
    check("strm_xor_consecutive", oc[1] - oc[0], 1);
    check("strm_drained", bus.out_valid, 0);
`ifdef REDUCE_TREE_SAMPLE_CNT_EN
    bus.out_ready = 1'b1;
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    check("cnt_clear", sample_cnt, 0);
    bus.x = 16'h0001; bus.y = 16'h0000; bus.op = OP_XOR; bus.in_valid = 1'b1;
    repeat (10) step();
    bus.in_valid = 1'b0;
    repeat (8) step();
    check("cnt_10", sample_cnt, 10);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int n = 0; n < 20 && !bus.out_valid; n++) step();
    check("cnt_pending_valid", bus.out_valid, 1);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    check("cnt_clr_wins", sample_cnt, 0);
    check("cnt_clr_transfer_done", bus.out_valid, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipelined_reduce_tree.md
Name: pipelined_reduce_tree

Overview:
- Parametrised, pipelined successor to the combinational two-operand OR/AND reduction tree.
- Reduces two GATES_NO-bit operand vectors (2*GATES_NO leaves) to a single bit through LEVELS registered stages.
- Reduction operator is selectable per sample and travels with the data through the pipeline.
- Valid/ready handshakes on both sides, so it sits directly between streaming producers and consumers in the lab datapath.

Parameters:
- LEVELS, 5, number of reduction levels and pipeline stages; legal values 1..8.
- GATES_NO, 2**(LEVELS-1), width of each operand vector; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input sample valid.
- in_ready  output  1  block can accept a sample this cycle.
- x  input  GATES_NO  operand vector A.
- y  input  GATES_NO  operand vector B.
- op  input  2  reduction operator for this sample: 0 ALT, 1 AND, 2 OR, 3 XOR.
- out_valid  output  1  out_z valid.
- out_ready  input  1  consumer accepts out_z this cycle.
- out_z  output  1  reduced result.
- out_op  output  2  op that produced out_z.

Behaviour:
- Reset (async, rst=1): all stage valid bits 0, all stage data 0, out_valid=0, out_z=0, out_op=0. in_ready=1 while rst=1 and after release. A sample in flight when reset asserts is discarded; no partial output.
- Handshake: a sample is accepted on a clk edge with in_valid&in_ready. Output transfer on out_valid&out_ready. x, y, op are sampled only on accept.
- Stall rule: advance = !out_valid | out_ready. in_ready = advance, combinational. When advance=0, every stage holds its data and valid. When advance=1, every stage shifts by one, bubbles included.
- Stage 1: bit i = f1(x[i], y[i]) for i in 0..GATES_NO-1, producing GATES_NO bits.
- Stage k (k=2..LEVELS): bit i = fk(s[2i], s[2i+1]) over the previous stage's register, halving the width. Stage LEVELS holds 1 bit, which drives out_z.
- Operator fk:
  - AND, OR, XOR: the same operator at every level.
  - ALT: odd k = AND, even k = OR.
- op is registered alongside the data in every stage. Each sample uses its own op, so mixing operators back-to-back causes no interaction.
- Latency: exactly LEVELS cycles from accept to out_valid=1 when out_ready is held 1. Throughput is 1 sample/clk with no bubbles.
- Simultaneous accept and output with the pipeline full and out_ready=1: both occur in the same cycle and no sample is lost.
- Samples leave in acceptance order. No reordering, no drops, no duplicates.
- out_z and out_op are stable while out_valid=1 and out_ready=0.
- LEVELS=1: single stage, GATES_NO=1, out_z = f1(x[0], y[0]) one cycle after accept.

Optional Feature:
- Macro REDUCE_TREE_SAMPLE_CNT_EN.
- Defined:
  - Adds output port sample_cnt (16 bits) counting completed output transfers (out_valid&out_ready).
  - Saturates at 16'hFFFF and is cleared to 0 by rst.
  - Adds input clr_cnt (1 bit), a synchronous clear; clr_cnt wins over a simultaneous increment.
- Undefined: neither port exists and no counter logic is built. Core behaviour is identical either way.

Decomposition:
- Package reduce_tree_pkg holds:
  - op encodings OP_ALT=2'd0, OP_AND=2'd1, OP_OR=2'd2, OP_XOR=2'd3;
  - function level_op(op, k) returning the effective AND/OR/XOR for level k;
  - constant CNT_W=16.
- Sub-module reduce_stage, parametrised by IN_W and LEVEL_IDX:
  - combinational pairwise reduce of IN_W bits to IN_W/2 (stage 1 wraps the x/y pairing);
  - register holding data, op and valid, with an advance enable.
- Top level instantiates LEVELS reduce_stage instances in a generate loop plus the handshake logic.

Test Plan (LEVELS=5, x/y 16 bits):
- Reset mid-stream: accept 3 samples, assert rst on the next cycle -> out_valid=0 and out_z=0 immediately; after release no stale output appears and in_ready=1.
- op=AND, x=y=16'hFFFF -> out_z=1 after exactly 5 cycles. Same with x=16'hFFFE -> out_z=0.
- op=XOR, x=16'h0001, y=16'h0000 -> out_z=1. Then x=16'h0003, y=16'h0000 -> out_z=0, on consecutive output cycles.
- op=ALT, x=16'h0003, y=16'h0003 (level 1 yields 16'h0003, level 2 bit0 = OR = 1, level 3 AND -> 0) -> out_z=0. With x=y=16'hFFFF -> out_z=1.
- Backpressure: stream 8 mixed samples while out_ready is 0 for 3 cycles mid-stream:
  - in_ready=0 during the stall;
  - all 8 results appear in order with the correct out_op;
  - out_z holds stable while stalled.
- With REDUCE_TREE_SAMPLE_CNT_EN: 10 transfers -> sample_cnt=10. Pulse clr_cnt in the same cycle as a transfer -> sample_cnt=0.
